instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 75 +++++++
 rtl/instr_encoder_if.sv | 29 ++
 rtl/instr_wbuf.sv | 50 +++++
 rtl/instr_encoder.sv | 111 +++++++++++
 tb/tb_instr_encoder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and the pure field-to-word encoder for the instruction loader.
// Field placement and immediate legality live here so the datapath stays a thin wrapper.
package instr_encoder_pkg;

  localparam int OP_W   = 2;
  localparam int REG_W  = 3;
  localparam int KK_W   = 8;
  localparam int ADDR_W = 8;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 9;

  typedef enum logic [OP_W-1:0] {
    OP_RRR = 2'd0,
    OP_RIF = 2'd1,
    OP_RI  = 2'd2,
    OP_RYI = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word;
  } wbuf_entry_t;

  // Opcode 3 reuses word[4:2] for immediate bits, so it overwrites the common rz slot.
  function automatic logic [WORD_W-1:0] encode(
    input opcode_e          op,
    input logic [REG_W-1:0] rx,
    input logic [REG_W-1:0] ry,
    input logic [REG_W-1:0] rz,
    input logic [REG_W-1:0] func,
    input logic [KK_W-1:0]  kk
  );
    logic [WORD_W-1:0] w;
    w        = '0;
    w[1:0]   = op;
    w[10:8]  = rx;
    w[4:2]   = rz;
    case (op)
      OP_RRR: begin
        w[13:11] = ry;
        w[7:5]   = func;
      end
      OP_RIF: begin
        w[15:11] = kk[4:0];
        w[7:5]   = func;
      end
      OP_RI: begin
        w[15:11] = kk[7:3];
        w[7:5]   = kk[2:0];
      end
      default: begin
        w[15:14] = kk[7:6];
        w[13:11] = ry;
        w[7:2]   = kk[5:0];
      end
    endcase
    return w;
  endfunction

  function automatic logic is_legal(input opcode_e op, input logic [KK_W-1:0] kk);
    case (op)
      OP_RRR:  return (kk == '0);
      OP_RIF:  return (kk[7:5] == 3'd0);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input handshake plus the instruction-memory write bus.
// master is the producer/memory side, slave is the encoder.
interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic [REG_W-1:0]  in_rx;
  logic [REG_W-1:0]  in_ry;
  logic [REG_W-1:0]  in_rz;
  logic [REG_W-1:0]  in_func;
  logic [KK_W-1:0]   in_kk;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_opcode, in_rx, in_ry, in_rz, in_func, in_kk, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_rx, in_ry, in_rz, in_func, in_kk, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_wbuf.sv
// Two-entry FIFO of {addr, word} between the encoder and instruction memory.
// A push is taken when full only if the head pops in the same cycle.
module instr_wbuf
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  wbuf_entry_t push_data,
  input  logic        pop,
  output wbuf_entry_t head,
  output logic        empty,
  output logic        full
);

  wbuf_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  level;
  logic        do_push;
  logic        do_pop;

  assign empty   = (level == 2'd0);
  assign full    = (level == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      level <= level + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Loads a run of encoded instructions into memory starting at base_addr.
// Illegal-immediate tuples are swallowed and only raise the sticky err flag.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [7:0]          count,
  input  logic                abort,
  instr_encoder_if.slave      bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e            state;
  logic [CNT_W-1:0]  legal_cnt;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  cnt_next;
  logic [ADDR_W-1:0] addr;
  opcode_e           op;
  logic              legal;
  logic              accept;
  logic              accept_legal;
  logic              buf_empty;
  logic              buf_full;
  logic              pop;
  wbuf_entry_t       push_data;
  wbuf_entry_t       head;

  assign op           = opcode_e'(bus.in_opcode);
  assign legal        = is_legal(op, bus.in_kk);
  assign bus.in_ready = (state == S_LOAD) && !buf_full && (legal_cnt < target) && !abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign accept_legal = accept && legal;
  assign cnt_next     = legal_cnt + {{(CNT_W-1){1'b0}}, accept_legal};
  assign push_data    = '{addr: addr,
                          word: encode(op, bus.in_rx, bus.in_ry, bus.in_rz, bus.in_func, bus.in_kk)};

  assign pop           = bus.mem_we && bus.mem_ready;
  assign bus.mem_we    = !buf_empty;
  assign bus.mem_addr  = head.addr;
  assign bus.mem_wdata = head.word;

  instr_wbuf u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (accept_legal),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // count==0 is latched as 256, which is why the counters are one bit wider than count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      legal_cnt <= '0;
      target    <= '0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            target    <= (count == 8'd0) ? 9'd256 : {1'b0, count};
            legal_cnt <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (legal) begin
              addr      <= addr + 8'd1;
              legal_cnt <= cnt_next;
            end else begin
              err <= 1'b1;
            end
          end
          if (cnt_next == target) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (buf_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed tuples push expected writes, a monitor pops them.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [7:0] count = 8'd0;
  logic       busy;
  logic       done;
  logic       err;

  int         total = 0;
  int         bad = 0;
  int         writes = 0;
  logic [7:0] exp_addr = 8'd0;
  exp_t       sb[$];

  instr_encoder_if bus();

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.mem_we && bus.mem_ready) begin
      writes++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h word 0x%0h, want no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = sb.pop_front();
        checkOutput("write_addr", {24'd0, bus.mem_addr}, {24'd0, e.addr});
        checkOutput("write_word", {16'd0, bus.mem_wdata}, {16'd0, e.word});
      end
    end
  end

  function automatic logic [15:0] modelWord(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                                            input logic [2:0] rz, input logic [2:0] func, input logic [7:0] kk);
    case (op)
      2'd0:    return {2'b00, ry, rx, func, rz, 2'b00};
      2'd1:    return {kk[4:0], rx, func, rz, 2'b01};
      2'd2:    return {kk[7:3], rx, kk[2:0], rz, 2'b10};
      default: return {kk[7:6], ry, rx, kk[5:0], 2'b11};
    endcase
  endfunction

  task automatic startLoad(input logic [7:0] base, input logic [7:0] cnt);
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    @(posedge clk); #1;
    start    = 1'b0;
    exp_addr = base;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                               input logic [2:0] rz, input logic [2:0] func, input logic [7:0] kk,
                               input bit expect_write, input logic [15:0] word);
    int waited;
    waited        = 0;
    bus.in_opcode = op;
    bus.in_rx     = rx;
    bus.in_ry     = ry;
    bus.in_rz     = rz;
    bus.in_func   = func;
    bus.in_kk     = kk;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, want 1");
    end else if (expect_write) begin
      sb.push_back({exp_addr, word});
      exp_addr = exp_addr + 8'd1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int  n;
    bit  seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    checkOutput("done_width", {31'd0, done}, 32'd0);
    checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    int cycles;
    int w0;
    logic [7:0]  iv;
    logic [1:0]  op;
    logic [7:0]  kk;

    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rx     = '0;
    bus.in_ry     = '0;
    bus.in_rz     = '0;
    bus.in_func   = '0;
    bus.in_kk     = '0;
    bus.mem_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-word load with first-write latency check.
    startLoad(8'h10, 8'd1);
    checkOutput("busy_in_load", {31'd0, busy}, 32'd1);
    applyStimulus(2'd2, 3'd3, 3'd0, 3'd5, 3'd0, 8'hA7, 1'b1, 16'hA3F6);
    @(negedge clk);
    checkOutput("latency_we", {31'd0, bus.mem_we}, 32'd1);
    waitDone(20);

    // Mixed opcodes with illegal tuples and an ignored mid-load start.
    startLoad(8'h20, 8'd4);
    applyStimulus(2'd1, 3'd1, 3'd0, 3'd7, 3'd2, 8'h13, 1'b1, 16'h995D);
    start = 1'b1; base_addr = 8'h99;
    @(posedge clk); #1;
    start = 1'b0;
    applyStimulus(2'd1, 3'd1, 3'd0, 3'd7, 3'd2, 8'h20, 1'b0, 16'h0000);
    checkOutput("err_set", {31'd0, err}, 32'd1);
    applyStimulus(2'd3, 3'd2, 3'd4, 3'd0, 3'd0, 8'hC5, 1'b1, 16'hE217);
    applyStimulus(2'd0, 3'd7, 3'd7, 3'd0, 3'd3, 8'h00, 1'b1, 16'h3F60);
    applyStimulus(2'd0, 3'd1, 3'd1, 3'd1, 3'd1, 8'h01, 1'b0, 16'h0000);
    applyStimulus(2'd2, 3'd3, 3'd0, 3'd5, 3'd0, 8'hA7, 1'b1, 16'hA3F6);
    waitDone(20);
    checkOutput("err_sticky", {31'd0, err}, 32'd1);

    // Back-pressure with address wrap.
    bus.mem_ready = 1'b0;
    startLoad(8'hFF, 8'd2);
    checkOutput("err_cleared_by_start", {31'd0, err}, 32'd0);
    applyStimulus(2'd1, 3'd1, 3'd0, 3'd7, 3'd2, 8'h13, 1'b1, 16'h995D);
    applyStimulus(2'd2, 3'd3, 3'd0, 3'd5, 3'd0, 8'hA7, 1'b1, 16'hA3F6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("hold_head_addr", {24'd0, bus.mem_addr}, 32'h0000_00FF);
      checkOutput("hold_head_word", {16'd0, bus.mem_wdata}, 32'h0000_995D);
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    waitDone(20);

    // count=0 means 256 back-to-back words.
    w0 = writes;
    startLoad(8'h80, 8'd0);
    accepted = 0;
    cycles   = 0;
    iv = 8'd0; op = 2'd0; kk = 8'd0;
    bus.in_valid = 1'b1;
    while (accepted < 256 && cycles < 3000) begin
      iv = accepted[7:0];
      op = iv[1:0];
      kk = (op == 2'd0) ? 8'd0 : (op == 2'd1) ? {3'd0, iv[4:0]} : ~iv;
      bus.in_opcode = op;
      bus.in_rx     = iv[2:0];
      bus.in_ry     = iv[5:3];
      bus.in_rz     = ~iv[2:0];
      bus.in_func   = iv[4:2];
      bus.in_kk     = kk;
      @(negedge clk);
      cycles++;
      if (bus.in_ready) begin
        sb.push_back({exp_addr, modelWord(op, iv[2:0], iv[5:3], ~iv[2:0], iv[4:2], kk)});
        exp_addr = exp_addr + 8'd1;
        accepted++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("sweep_accepts", accepted, 32'd256);
    waitDone(20);
    checkOutput("sweep_writes", writes - w0, 32'd256);

    // Abort with two words buffered; err must survive.
    bus.mem_ready = 1'b0;
    startLoad(8'h40, 8'd5);
    applyStimulus(2'd0, 3'd1, 3'd1, 3'd1, 3'd1, 8'h05, 1'b0, 16'h0000);
    applyStimulus(2'd2, 3'd1, 3'd0, 3'd1, 3'd0, 8'h11, 1'b0, 16'h0000);
    applyStimulus(2'd2, 3'd2, 3'd0, 3'd2, 3'd0, 8'h22, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("pre_abort_we", {31'd0, bus.mem_we}, 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    end
    checkOutput("abort_err_kept", {31'd0, err}, 32'd1);

    // start together with abort is not honoured.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("start_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("start_abort_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;

    // Reset mid-load discards buffered words.
    bus.mem_ready = 1'b0;
    startLoad(8'h50, 8'd3);
    applyStimulus(2'd3, 3'd1, 3'd2, 3'd0, 3'd0, 8'h3C, 1'b0, 16'h0000);
    applyStimulus(2'd3, 3'd2, 3'd3, 3'd0, 3'd0, 8'h4D, 1'b0, 16'h0000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      checkOutput("post_rst_done", {31'd0, done}, 32'd0);
    end

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
